// File: rtl/pipe_adder_seg.sv
// Segmented pipelined adder: a WIDTH-bit add split into STAGES ripple segments, one segment per stage.
// Latency: STAGES register stages; a pair accepted at edge N is on the outputs after edge N+STAGES-1.
// Backpressure: stall freezes every stage and drops in_ready; flush (over stall) clears all in-flight work.
//
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   in_valid/in_ready operand handshake; in_ready = !stall
//   a, b, cin         operands and carry into bit 0
//   sub               (only with PIPE_ADDER_SUB_EN) subtract: b' = ~b, carry-in forced to 1
//   stall, flush      freeze whole pipeline / synchronous clear of all stages
//   out_valid         sum/cout/ovf hold a completed result
//   sum, cout, ovf    a+b'+cin mod 2^WIDTH, carry out of MSB, signed overflow
//
// Optional feature macro: PIPE_ADDER_SUB_EN (adds the sub port). Default build is add-only.
// WIDTH must be an exact multiple of STAGES (1..8).

module pipe_adder_seg #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    input  logic             stall,
    input  logic             flush,
    output logic             out_valid,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = WIDTH / STAGES;

    // One pipeline stage. Operands travel with the transaction so that
    // stage k never looks at the live a/b ports; only the bits above
    // k*SEG are still consumed downstream, the rest just ride along.
    typedef struct packed {
        logic             vld;
        logic             cry;
        logic [WIDTH-1:0] psum;
        logic [WIDTH-1:0] opa;
        logic [WIDTH-1:0] opb;
    } stage_t;

    stage_t           stg_q [STAGES];
    stage_t           stg_d [STAGES];
    stage_t           src0;
    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic             ovf_q;
    logic             ovf_d;

    // Add segment idx of the operands carried in src, using src.cry as the
    // incoming carry; the segment's top bit becomes the outgoing carry.
    function automatic stage_t seg_step(input stage_t src, input int idx);
        stage_t     r;
        logic [SEG:0] seg;
        r   = src;
        seg = {1'b0, src.opa[idx*SEG +: SEG]}
            + {1'b0, src.opb[idx*SEG +: SEG]}
            + {{SEG{1'b0}}, src.cry};
        r.psum[idx*SEG +: SEG] = seg[SEG-1:0];
        r.cry                  = seg[SEG];
        return r;
    endfunction

    always_comb begin
        b_eff   = b;
        cin_eff = cin;
`ifdef PIPE_ADDER_SUB_EN
        if (sub) begin
            b_eff   = ~b;
            cin_eff = 1'b1;
        end
`endif
        // Bubbles enter as all-zero data so idle outputs settle to zero.
        src0 = '0;
        if (in_valid) begin
            src0.vld = 1'b1;
            src0.cry = cin_eff;
            src0.opa = a;
            src0.opb = b_eff;
        end

        for (int s = 0; s < STAGES; s++) begin
            stg_d[s] = '0;
        end
        stg_d[0] = seg_step(src0, 0);
        for (int s = 1; s < STAGES; s++) begin
            stg_d[s] = seg_step(stg_q[s-1], s);
        end

        // Final stage: overflow from the carried operand MSBs and the new sum MSB.
        ovf_d = (stg_d[STAGES-1].opa[WIDTH-1] == stg_d[STAGES-1].opb[WIDTH-1])
             && (stg_d[STAGES-1].psum[WIDTH-1] != stg_d[STAGES-1].opa[WIDTH-1]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                stg_q[s] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (flush) begin
            // Flush wins over stall and drops whatever is on the inputs.
            for (int s = 0; s < STAGES; s++) begin
                stg_q[s] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (!stall) begin
            for (int s = 0; s < STAGES; s++) begin
                stg_q[s] <= stg_d[s];
            end
            ovf_q <= ovf_d;
        end
    end

    assign in_ready  = !stall;
    assign out_valid = stg_q[STAGES-1].vld;
    assign sum       = stg_q[STAGES-1].psum;
    assign cout      = stg_q[STAGES-1].cry;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder_seg.sv
// Scoreboard bench for pipe_adder_seg: expected results queued at acceptance, checked on output.
// Latency is measured in advancing (non-stalled) cycles and in wall cycles for directed cases.
// Stimulus mixes directed cases with a random stream including stall and flush.

module tb_pipe_adder_seg;

    localparam int W = 32;
    localparam int S = 4;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         stall;
    logic         flush;
    logic         out_valid;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
`ifdef PIPE_ADDER_SUB_EN
    logic         sub;
`endif

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           tag;
    } exp_t;

    exp_t         sbq[$];
    int           n_pass = 0;
    int           n_chk  = 0;
    int           cyc    = 0;
    int           adv_cnt = 0;
    logic         adv_q  = 1'b0;
    int           last_acc_cyc = -1000;
    int           last_out_cyc = -2000;
    logic [W-1:0] last_sum  = '0;
    logic         last_cout = 1'b0;
    logic         last_ovf  = 1'b0;

    pipe_adder_seg #(.WIDTH(W), .STAGES(S)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef PIPE_ADDER_SUB_EN
        .sub      (sub),
`endif
        .stall    (stall),
        .flush    (flush),
        .out_valid(out_valid),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    endtask

    // Reference: plain unsigned sum for result/carry, true signed range test for overflow.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic c, input logic sb);
        exp_t       e;
        logic [W-1:0] be;
        logic       ce;
        logic [W:0] full;
        longint     sa, sbb, ss, mx, mn;
        be   = sb ? ~bv : bv;
        ce   = sb ? 1'b1 : c;
        full = {1'b0, av} + {1'b0, be} + {{W{1'b0}}, ce};
        sa   = longint'($signed(av));
        sbb  = longint'($signed(be));
        ss   = sa + sbb + longint'(ce);
        mx   = (longint'(1) <<< (W-1)) - 1;
        mn   = -(longint'(1) <<< (W-1));
        e.sum  = full[W-1:0];
        e.cout = full[W];
        e.ovf  = (ss > mx) || (ss < mn);
        e.tag  = 0;
        return e;
    endfunction

    // Issue side: record each accepted transaction with its advance index.
    initial begin
        exp_t e;
        logic sbv;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                adv_q = 1'b0;
            end else begin
                adv_q = !stall && !flush;
                if (flush) begin
                    sbq.delete();
                end else if (!stall) begin
                    adv_cnt++;
                    if (in_valid) begin
`ifdef PIPE_ADDER_SUB_EN
                        sbv = sub;
`else
                        sbv = 1'b0;
`endif
                        e     = model(a, b, cin, sbv);
                        e.tag = adv_cnt;
                        sbq.push_back(e);
                        last_acc_cyc = cyc;
                    end
                end
            end
        end
    end

    // Monitor: compare whenever the pipeline advanced and a result is presented.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && adv_q) begin
                if (out_valid) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_out_valid", out_valid, 1'b0);
                    end else begin
                        e = sbq.pop_front();
                        chk("sum", sum, e.sum);
                        chk("cout", cout, e.cout);
                        chk("ovf", ovf, e.ovf);
                        chk("latency_adv", adv_cnt, e.tag + S - 1);
                        last_out_cyc = cyc;
                        last_sum     = sum;
                        last_cout    = cout;
                        last_ovf     = ovf;
                    end
                end else if (sbq.size() > 0 && adv_cnt >= sbq[0].tag + S - 1) begin
                    chk("missing_out_valid", out_valid, 1'b1);
                    void'(sbq.pop_front());
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
        in_valid = 1'b1;
        a        = av;
        b        = bv;
        cin      = c;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        cin      = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [W+2:0] snap;

        rst   = 1'b0;
        stall = 1'b1;
        flush = 1'b0;
`ifdef PIPE_ADDER_SUB_EN
        sub   = 1'b0;
`endif
        idle();
        #1 rst = 1'b1;
        #2;
        // Reset state; in_ready follows stall even in reset.
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_sum", sum, '0);
        chk("rst_cout", cout, 1'b0);
        chk("rst_ovf", ovf, 1'b0);
        chk("rst_in_ready_stalled", in_ready, 1'b0);
        stall = 1'b0;
        #1;
        chk("rst_in_ready", in_ready, 1'b1);
        repeat (2) step();
        rst = 1'b0;
        step();

        // Single transaction: 5 + 3.
        drive(32'h0000_0005, 32'h0000_0003, 1'b0);
        step();
        idle();
        repeat (S + 2) step();
        chk("t1_wall_latency", last_out_cyc - last_acc_cyc, S - 1);
        chk("t1_sum", last_sum, 32'h0000_0008);

        // Back-to-back stream, no mixing between transactions.
        drive(32'hFFFF_FFFF, 32'h0000_0001, 1'b0); step();
        drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0); step();
        drive(32'h1234_5678, 32'h1111_1111, 1'b1); step();
        idle();
        repeat (S + 2) step();
        chk("t2_last_sum", last_sum, 32'h2345_678A);

        // Stall for three cycles mid-flight.
        drive(32'h0000_0005, 32'h0000_0003, 1'b0);
        step();
        idle();
        step();
        snap  = {out_valid, sum, cout, ovf};
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t3_in_ready", in_ready, 1'b0);
            step();
            chk("t3_frozen", {out_valid, sum, cout, ovf}, snap);
        end
        stall = 1'b0;
        repeat (S + 3) step();
        chk("t3_wall_latency", last_out_cyc - last_acc_cyc, S - 1 + 3);
        chk("t3_sum", last_sum, 32'h0000_0008);

        // Flush with stall and a valid input in the same cycle.
        drive(32'h0000_1111, 32'h0000_2222, 1'b0); step();
        drive(32'h0000_3333, 32'h0000_4444, 1'b1); step();
        drive(32'h8000_0000, 32'h8000_0000, 1'b0); step();
        drive(32'hAAAA_AAAA, 32'h5555_5555, 1'b1);
        flush = 1'b1;
        stall = 1'b1;
        step();
        flush = 1'b0;
        stall = 1'b0;
        idle();
        for (int i = 0; i < 4; i++) begin
            chk("t4_out_valid", out_valid, 1'b0);
            chk("t4_sum", sum, '0);
            step();
        end

        // Asynchronous reset pulse between edges with a full pipeline.
        for (int i = 0; i < S; i++) begin
            drive($urandom, $urandom, 1'(i));
            step();
        end
        idle();
        #1 rst = 1'b1;
        #1;
        chk("t5_out_valid", out_valid, 1'b0);
        chk("t5_sum", sum, '0);
        chk("t5_cout", cout, 1'b0);
        chk("t5_ovf", ovf, 1'b0);
        sbq.delete();
        adv_q = 1'b0;
        rst   = 1'b0;
        step();
        drive(32'hDEAD_0000, 32'h0000_BEEF, 1'b1);
        step();
        idle();
        repeat (S + 2) step();
        chk("t5_wall_latency", last_out_cyc - last_acc_cyc, S - 1);
        chk("t5_sum_after", last_sum, 32'hDEAD_BEF0);

`ifdef PIPE_ADDER_SUB_EN
        // Subtraction.
        sub = 1'b1;
        drive(32'h0000_0003, 32'h0000_0005, 1'b0); step();
        drive(32'h8000_0000, 32'h0000_0001, 1'b0); step();
        sub = 1'b0;
        idle();
        repeat (S + 2) step();
        chk("t7_sum", last_sum, 32'h7FFF_FFFF);
        chk("t7_cout", last_cout, 1'b1);
        chk("t7_ovf", last_ovf, 1'b1);
`endif

        // Random stream with occasional stall and flush.
        for (int i = 0; i < 400; i++) begin
            in_valid = ($urandom_range(0, 9) < 7);
            a        = pick();
            b        = pick();
            cin      = 1'($urandom_range(0, 1));
            stall    = ($urandom_range(0, 9) == 0);
            flush    = ($urandom_range(0, 39) == 0);
`ifdef PIPE_ADDER_SUB_EN
            sub      = 1'($urandom_range(0, 1));
`endif
            step();
        end
        stall = 1'b0;
        flush = 1'b0;
        idle();
        repeat (S + 3) step();
        chk("drain_empty", sbq.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
